perf_counter_bank: RTL and testbench

Parametrised event-counter bank replacing the fixed, hard-wired performance counters in the CPU top level. It counts NUM_CNT independent event channels, each able to add up to 2^INC_WIDTH-1 per cycle, so dual register-file reads in one instruction count correctly. Counting freezes while the core is halted. A snapshot bank, sticky overflow flags, a per-channel enable mask and a registered read port let the FPGA debug logic sample counters coherently.

---
 rtl/perf_pkg.sv | 11 +
 rtl/perf_counter_slice.sv | 54 +++++
 rtl/perf_counter_bank.sv | 80 ++++++++
 tb/tb_perf_counter_bank.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared constants for the performance counter bank: default widths and
// the read bank-select encoding.
package perf_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 32;
  localparam int unsigned INC_WIDTH_DEF = 2;

  localparam logic BANK_LIVE   = 1'b0;
  localparam logic BANK_SHADOW = 1'b1;

endpackage

// File: rtl/perf_counter_slice.sv
// One counter channel: live counter with carry-detecting adder, wrap or
// saturate on overflow, sticky overflow flag and a snapshot register.
module perf_counter_slice
  import perf_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int unsigned INC_WIDTH = INC_WIDTH_DEF,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_count_en,
  input  logic [INC_WIDTH-1:0] i_inc,
  input  logic                 i_clr,
  input  logic                 i_snap,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic [CNT_WIDTH-1:0] o_shadow,
  output logic                 o_ovf
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_shadow;
  logic                 r_ovf;
  logic [CNT_WIDTH:0]   w_sum;

  assign w_sum = {1'b0, r_cnt} + (CNT_WIDTH + 1)'(i_inc);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_ovf    <= 1'b0;
    end else begin
      // Snapshot takes the pre-update value, so snap+clr acts as read-and-clear.
      if (i_snap) r_shadow <= r_cnt;
      if (i_clr) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (i_count_en) begin
        if (w_sum[CNT_WIDTH]) begin
          r_ovf <= 1'b1;
          r_cnt <= SATURATE ? {CNT_WIDTH{1'b1}} : w_sum[CNT_WIDTH-1:0];
        end else begin
          r_cnt <= w_sum[CNT_WIDTH-1:0];
        end
      end
    end
  end

  assign o_cnt    = r_cnt;
  assign o_shadow = r_shadow;
  assign o_ovf    = r_ovf;

endmodule

// File: rtl/perf_counter_bank.sv
// Parametrised bank of event counters with enable mask, snapshot bank,
// sticky overflow flags and a one-cycle registered read port.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned NUM_CNT   = 8,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int unsigned INC_WIDTH = INC_WIDTH_DEF,
  parameter bit          SATURATE  = 1'b0,
  parameter int unsigned AW        = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_halt,
  input  logic [NUM_CNT*INC_WIDTH-1:0] i_event_inc,
  input  logic                         i_en_we,
  input  logic [NUM_CNT-1:0]           i_en_wdata,
  input  logic                         i_clr,
  input  logic                         i_snap,
  input  logic                         i_rd_en,
  input  logic                         i_rd_shadow,
  input  logic [AW-1:0]                i_rd_addr,
  output logic [CNT_WIDTH-1:0]         o_rd_data,
  output logic                         o_rd_valid,
  output logic [NUM_CNT-1:0]           o_ovf,
  output logic                         o_any_ovf
);

  logic [NUM_CNT-1:0]   r_en;
  logic [CNT_WIDTH-1:0] r_rd_data;
  logic                 r_rd_valid;
  logic [CNT_WIDTH-1:0] w_cnt    [NUM_CNT];
  logic [CNT_WIDTH-1:0] w_shadow [NUM_CNT];
  logic [CNT_WIDTH-1:0] w_rd_sel;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_slice
    perf_counter_slice #(
      .CNT_WIDTH (CNT_WIDTH),
      .INC_WIDTH (INC_WIDTH),
      .SATURATE  (SATURATE)
    ) u_slice (
      .clk        (clk),
      .reset      (reset),
      .i_count_en (~i_halt & r_en[g]),
      .i_inc      (i_event_inc[g*INC_WIDTH +: INC_WIDTH]),
      .i_clr      (i_clr),
      .i_snap     (i_snap),
      .o_cnt      (w_cnt[g]),
      .o_shadow   (w_shadow[g]),
      .o_ovf      (o_ovf[g])
    );
  end

  // Addresses past the last channel match nothing and read as zero.
  always_comb begin
    w_rd_sel = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (i_rd_addr == AW'(i)) begin
        w_rd_sel = (i_rd_shadow == BANK_SHADOW) ? w_shadow[i] : w_cnt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en       <= '1;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (i_en_we) r_en <= i_en_wdata;
      r_rd_valid <= i_rd_en;
      if (i_rd_en) r_rd_data <= w_rd_sel;
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_any_ovf  = |o_ovf;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Randomised and directed bench for perf_counter_bank: a wrap and a saturate
// instance share stimulus and are checked against an arithmetic reference model.
module tb_perf_counter_bank;

  localparam int N  = 6;
  localparam int W  = 8;
  localparam int IW = 2;
  localparam int AW = 3;
  localparam int MAXV = (1 << W);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, halt, en_we, clr, snap, rd_en, rd_shadow;
  logic [N*IW-1:0] event_inc;
  logic [N-1:0]  en_wdata;
  logic [AW-1:0] rd_addr;

  logic [W-1:0]  rd_data_w, rd_data_s;
  logic          rd_valid_w, rd_valid_s;
  logic [N-1:0]  ovf_w, ovf_s;
  logic          any_ovf_w, any_ovf_s;

  perf_counter_bank #(
    .NUM_CNT (N), .CNT_WIDTH (W), .INC_WIDTH (IW), .SATURATE (1'b0), .AW (AW)
  ) dut_wrap (
    .clk (clk), .reset (reset), .i_halt (halt), .i_event_inc (event_inc),
    .i_en_we (en_we), .i_en_wdata (en_wdata), .i_clr (clr), .i_snap (snap),
    .i_rd_en (rd_en), .i_rd_shadow (rd_shadow), .i_rd_addr (rd_addr),
    .o_rd_data (rd_data_w), .o_rd_valid (rd_valid_w), .o_ovf (ovf_w),
    .o_any_ovf (any_ovf_w)
  );

  perf_counter_bank #(
    .NUM_CNT (N), .CNT_WIDTH (W), .INC_WIDTH (IW), .SATURATE (1'b1), .AW (AW)
  ) dut_sat (
    .clk (clk), .reset (reset), .i_halt (halt), .i_event_inc (event_inc),
    .i_en_we (en_we), .i_en_wdata (en_wdata), .i_clr (clr), .i_snap (snap),
    .i_rd_en (rd_en), .i_rd_shadow (rd_shadow), .i_rd_addr (rd_addr),
    .o_rd_data (rd_data_s), .o_rd_valid (rd_valid_s), .o_ovf (ovf_s),
    .o_any_ovf (any_ovf_s)
  );

  // Reference model: index 0 = wrap instance, 1 = saturate instance.
  int m_cnt [2][N];
  int m_sh  [2][N];
  bit m_ovf [2][N];
  bit m_en  [N];
  int m_rd  [2];
  bit m_vld;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        m_rd[d] = 0;
        for (int i = 0; i < N; i++) begin
          m_cnt[d][i] = 0; m_sh[d][i] = 0; m_ovf[d][i] = 0;
        end
      end
      for (int i = 0; i < N; i++) m_en[i] = 1;
      m_vld = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (rd_en) begin
          if (int'(rd_addr) >= N) m_rd[d] = 0;
          else m_rd[d] = rd_shadow ? m_sh[d][rd_addr] : m_cnt[d][rd_addr];
        end
        for (int i = 0; i < N; i++) begin
          int s;
          if (snap) m_sh[d][i] = m_cnt[d][i];
          s = m_cnt[d][i] + int'(event_inc[i*IW +: IW]);
          if (clr) begin
            m_cnt[d][i] = 0; m_ovf[d][i] = 0;
          end else if (!halt && m_en[i]) begin
            if (s >= MAXV) begin
              m_ovf[d][i] = 1;
              m_cnt[d][i] = (d == 1) ? MAXV - 1 : s - MAXV;
            end else begin
              m_cnt[d][i] = s;
            end
          end
        end
      end
      m_vld = rd_en;
      if (en_we) for (int i = 0; i < N; i++) m_en[i] = en_wdata[i];
    end
  endtask

  task automatic step();
    logic [N-1:0] ev0, ev1;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < N; i++) begin
      ev0[i] = m_ovf[0][i];
      ev1[i] = m_ovf[1][i];
    end
    check("rd_valid_wrap", rd_valid_w, m_vld);
    check("rd_valid_sat", rd_valid_s, m_vld);
    check("rd_data_wrap", rd_data_w, m_rd[0]);
    check("rd_data_sat", rd_data_s, m_rd[1]);
    check("ovf_wrap", ovf_w, ev0);
    check("ovf_sat", ovf_s, ev1);
    check("any_ovf_wrap", any_ovf_w, |ev0);
    check("any_ovf_sat", any_ovf_s, |ev1);
  endtask

  task automatic set_inc(input int ch, input int v);
    event_inc[ch*IW +: IW] = IW'(v);
  endtask

  task automatic read(input bit bank, input int addr);
    rd_en = 1; rd_shadow = bank; rd_addr = AW'(addr);
    step();
    rd_en = 0;
  endtask

  initial begin
    reset = 1; halt = 0; en_we = 0; clr = 0; snap = 0; rd_en = 0; rd_shadow = 0;
    event_inc = '0; en_wdata = '0; rd_addr = '0;
    step(); step();
    reset = 0;
    check("reset_valid", rd_valid_w, 0);
    check("reset_ovf", ovf_w, 0);

    // Reset then count
    set_inc(0, 1);
    repeat (10) step();
    set_inc(0, 0);
    read(0, 0);
    check("tp_ch0_10", rd_data_w, 10);
    check("tp_ch0_valid", rd_valid_w, 1);
    step();
    check("tp_valid_drop", rd_valid_w, 0);
    for (int c = 1; c < N; c++) begin
      read(0, c);
      check("tp_other_zero", rd_data_w, 0);
    end

    // Dual increment and halt
    set_inc(1, 2);
    repeat (5) step();
    halt = 1;
    repeat (4) step();
    halt = 0; set_inc(1, 0);
    read(0, 1);
    check("tp_halt_10", rd_data_w, 10);
    set_inc(1, 2); step(); set_inc(1, 0);
    read(0, 1);
    check("tp_halt_12", rd_data_w, 12);

    // Wrap and saturate at the 8-bit boundary
    clr = 1; step(); clr = 0;
    set_inc(4, 3); repeat (84) step();
    set_inc(4, 2); step(); set_inc(4, 0);
    read(0, 4);
    check("tp_254_wrap", rd_data_w, 254);
    check("tp_254_sat", rd_data_s, 254);
    set_inc(4, 3); step(); set_inc(4, 0);
    read(0, 4);
    check("tp_wrap_1", rd_data_w, 1);
    check("tp_sat_255", rd_data_s, 255);
    check("tp_ovf4_wrap", ovf_w[4], 1);
    check("tp_any_ovf_wrap", any_ovf_w, 1);
    check("tp_ovf4_sat", ovf_s[4], 1);
    set_inc(4, 3); repeat (3) step(); set_inc(4, 0);
    read(0, 4);
    check("tp_sat_hold", rd_data_s, 255);
    clr = 1; step(); clr = 0;
    read(0, 4);
    check("tp_clr_cnt", rd_data_w, 0);
    check("tp_clr_ovf", ovf_w, 0);

    // Snap and clr together
    set_inc(2, 1); repeat (37) step(); set_inc(2, 0);
    snap = 1; clr = 1; rd_en = 1; rd_shadow = 0; rd_addr = 2;
    step();
    snap = 0; clr = 0; rd_en = 0;
    check("tp_snapclr_live_pre", rd_data_w, 37);
    read(1, 2);
    check("tp_shadow_37", rd_data_w, 37);
    read(0, 2);
    check("tp_live_0", rd_data_w, 0);

    // Enable mask and out-of-range address
    set_inc(3, 1); en_we = 1; en_wdata = 6'b110111;
    step();
    en_we = 0;
    repeat (5) step();
    set_inc(3, 0);
    read(0, 3);
    check("tp_mask_frozen", rd_data_w, 1);
    read(0, 6);
    check("tp_addr6_data", rd_data_w, 0);
    check("tp_addr6_valid", rd_valid_w, 1);
    read(1, 7);
    check("tp_addr7_data", rd_data_w, 0);

    // Reset mid-count
    event_inc = '1;
    repeat (3) step();
    reset = 1; step(); reset = 0;
    event_inc = '0;
    read(0, 0);
    check("tp_rst_cnt", rd_data_w, 0);
    set_inc(3, 1); step(); set_inc(3, 0);
    read(0, 3);
    check("tp_rst_mask", rd_data_w, 1);

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      reset     = ($urandom % 300) == 0;
      halt      = ($urandom % 4) == 0;
      event_inc = N*IW'($urandom);
      en_we     = ($urandom % 16) == 0;
      en_wdata  = N'($urandom);
      clr       = ($urandom % 64) == 0;
      snap      = ($urandom % 8) == 0;
      rd_en     = $urandom % 2;
      rd_shadow = $urandom % 2;
      rd_addr   = AW'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
